// File: rtl/skolem_inv_sweep_ctrl_if.sv
// Bus between the sweep controller and its surroundings: the harness/CSR
// control and status signals, plus the operand/result lines to the Skolem
// datapath. The controller uses the slave view; the harness uses the master view.
interface skolem_inv_sweep_ctrl_if #(
  parameter int W  = 4,
  parameter int CW = 2*W+1
);
  logic          start_i;
  logic          abort_i;
  logic [W-1:0]  sk_s_o;
  logic [W-1:0]  sk_t_o;
  logic [W-1:0]  sk_x_i;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] ic_cnt_o;
  logic [CW-1:0] pass_cnt_o;
  logic [CW-1:0] fail_cnt_o;
  logic          fail_vld_o;
  logic [3*W-1:0] fail_vec_o;

  modport slave (
    input  start_i, abort_i, sk_x_i,
    output sk_s_o, sk_t_o, busy_o, done_o,
           ic_cnt_o, pass_cnt_o, fail_cnt_o, fail_vld_o, fail_vec_o
  );

  modport master (
    output start_i, abort_i, sk_x_i,
    input  sk_s_o, sk_t_o, busy_o, done_o,
           ic_cnt_o, pass_cnt_o, fail_cnt_o, fail_vld_o, fail_vec_o
  );
endinterface

// File: rtl/skolem_inv_sweep_ctrl.sv
// Exhaustive sweep controller for a Skolem block solving (x >>u s) <s t.
// Every {s,t} pair is applied, x is sampled after SK_LAT cycles, and whenever
// the invertibility condition holds the result is checked and counted.
// Optional feature: define SKOLEM_STOP_ON_FAIL_EN to end the sweep at the
// first recorded failure.
module skolem_inv_sweep_ctrl #(
  parameter int W      = 4,
  parameter int SK_LAT = 0,
  parameter int CW     = 2*W+1
) (
  input logic                    clk,
  input logic                    rst_n,
  skolem_inv_sweep_ctrl_if.slave bus
);
  localparam int IW = 2*W;
  localparam int LW = (SK_LAT > 1) ? $clog2(SK_LAT + 1) : 1;
  localparam logic [LW-1:0] LAT_INIT = (SK_LAT > 0) ? LW'(SK_LAT - 1) : {LW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t         state_r, state_nxt;
  logic [IW-1:0]  idx_r;
  logic [LW-1:0]  lat_cnt_r;
  logic [W-1:0]   sk_s_r, sk_t_r;
  logic [CW-1:0]  ic_cnt_r, pass_cnt_r, fail_cnt_r;
  logic           fail_vld_r;
  logic [3*W-1:0] fail_vec_r;
  logic           busy_r, done_r;

  logic start_go_s, chk_s, ic_s, ok_s, fail_s, last_s, stop_s;

  // Invertibility condition: s==0 needs t != INT_MIN, otherwise t must be positive.
  function automatic logic ic_fn(input logic [W-1:0] s, input logic [W-1:0] t);
    logic [W-1:0] min_neg;
    min_neg = {1'b1, {(W-1){1'b0}}};
    if (s == {W{1'b0}}) begin
      ic_fn = (t != min_neg);
    end else begin
      ic_fn = ($signed(t) > $signed({W{1'b0}}));
    end
  endfunction

  // Result check: logical shift (amounts >= W give 0), then signed compare.
  function automatic logic check_fn(input logic [W-1:0] s, input logic [W-1:0] t,
                                    input logic [W-1:0] x);
    logic [W-1:0] sh;
    sh = x >> s;
    check_fn = ($signed(sh) < $signed(t));
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (v == {CW{1'b1}}) ? v : v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  assign start_go_s = (state_r == ST_IDLE) && bus.start_i && !bus.abort_i;
  assign chk_s      = (state_r == ST_CHECK) && !bus.abort_i;
  assign ic_s       = ic_fn(sk_s_r, sk_t_r);
  assign ok_s       = check_fn(sk_s_r, sk_t_r, bus.sk_x_i);
  assign fail_s     = ic_s && !ok_s;
  assign last_s     = (idx_r == {IW{1'b1}});
`ifdef SKOLEM_STOP_ON_FAIL_EN
  assign stop_s     = fail_s;
`else
  assign stop_s     = 1'b0;
`endif

  // Next-state logic; abort wins over everything outside IDLE.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_go_s) state_nxt = ST_APPLY;
        else            state_nxt = ST_IDLE;
      end
      ST_APPLY: begin
        if (bus.abort_i)      state_nxt = ST_IDLE;
        else if (SK_LAT == 0) state_nxt = ST_CHECK;
        else                  state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.abort_i)                   state_nxt = ST_IDLE;
        else if (lat_cnt_r == {LW{1'b0}})  state_nxt = ST_CHECK;
        else                               state_nxt = ST_WAIT;
      end
      ST_CHECK: begin
        if (bus.abort_i)          state_nxt = ST_IDLE;
        else if (stop_s || last_s) state_nxt = ST_DONE;
        else                      state_nxt = ST_APPLY;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt;
  end

  // Sweep index, latency counter, operand registers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r     <= {IW{1'b0}};
      lat_cnt_r <= {LW{1'b0}};
      sk_s_r    <= {W{1'b0}};
      sk_t_r    <= {W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      busy_r <= (state_nxt == ST_APPLY) || (state_nxt == ST_WAIT) || (state_nxt == ST_CHECK);
      done_r <= (state_nxt == ST_DONE);
      if (start_go_s) begin
        idx_r <= {IW{1'b0}};
      end else if (chk_s && !last_s && !stop_s) begin
        idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
      end
      if (state_r == ST_APPLY) begin
        sk_s_r    <= idx_r[IW-1:W];
        sk_t_r    <= idx_r[W-1:0];
        lat_cnt_r <= LAT_INIT;
      end else if ((state_r == ST_WAIT) && (lat_cnt_r != {LW{1'b0}})) begin
        lat_cnt_r <= lat_cnt_r - {{(LW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Result counters and first-failure capture; cleared when a sweep starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_cnt_r   <= {CW{1'b0}};
      pass_cnt_r <= {CW{1'b0}};
      fail_cnt_r <= {CW{1'b0}};
      fail_vld_r <= 1'b0;
      fail_vec_r <= {(3*W){1'b0}};
    end else if (start_go_s) begin
      ic_cnt_r   <= {CW{1'b0}};
      pass_cnt_r <= {CW{1'b0}};
      fail_cnt_r <= {CW{1'b0}};
      fail_vld_r <= 1'b0;
      fail_vec_r <= {(3*W){1'b0}};
    end else if (chk_s && ic_s) begin
      ic_cnt_r <= sat_inc(ic_cnt_r);
      if (ok_s) begin
        pass_cnt_r <= sat_inc(pass_cnt_r);
      end else begin
        fail_cnt_r <= sat_inc(fail_cnt_r);
        if (!fail_vld_r) begin
          fail_vld_r <= 1'b1;
          fail_vec_r <= {sk_s_r, sk_t_r, bus.sk_x_i};
        end
      end
    end
  end

  assign bus.sk_s_o     = sk_s_r;
  assign bus.sk_t_o     = sk_t_r;
  assign bus.busy_o     = busy_r;
  assign bus.done_o     = done_r;
  assign bus.ic_cnt_o   = ic_cnt_r;
  assign bus.pass_cnt_o = pass_cnt_r;
  assign bus.fail_cnt_o = fail_cnt_r;
  assign bus.fail_vld_o = fail_vld_r;
  assign bus.fail_vec_o = fail_vec_r;
endmodule
